// File: rtl/wb_dbg_pkg.sv
// Shared command/status codes and FSM encoding for the UART-to-Wishbone debug bridge.
package wb_dbg_pkg;

  localparam logic [7:0] CMD_WRITE = 8'h01;
  localparam logic [7:0] CMD_READ  = 8'h02;

  localparam logic [7:0] STAT_ACK = 8'h00;
  localparam logic [7:0] STAT_ERR = 8'hE1;
  localparam logic [7:0] STAT_RTY = 8'hE2;
  localparam logic [7:0] STAT_TMO = 8'hE3;

  // start + 8 data + stop
  localparam int UART_FRAME_BITS = 10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_WDATA,
    ST_BUS,
    ST_STAT,
    ST_RDATA
  } state_t;

endpackage

// File: rtl/dbg_uart_phy.sv
// 8N1 UART receiver/transmitter: rx emits a one-cycle byte-valid pulse,
// tx accepts a byte when tx_valid and tx_ready are both high.
module dbg_uart_phy
  import wb_dbg_pkg::*;
#(
  parameter int CLK_DIV = 434
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       rxd,
  output logic       txd,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready
);

  localparam int CNT_W = $clog2(CLK_DIV);
  localparam logic [CNT_W-1:0] FULL_BIT = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] HALF_BIT = CNT_W'(CLK_DIV / 2 - 1);
  localparam logic [3:0] LAST_BIT = 4'(UART_FRAME_BITS - 1);

  logic             rxd_meta, rxd_sync, rxd_last;
  logic             rx_busy;
  logic [CNT_W-1:0] rx_cnt;
  logic [3:0]       rx_bit;
  logic [7:0]       rx_shift;

  logic             tx_busy;
  logic             txd_q;
  logic [CNT_W-1:0] tx_cnt;
  logic [3:0]       tx_bit;
  logic [8:0]       tx_shift;

  // Only a falling edge arms the receiver, so a line held low after a bad stop bit is not re-read as a start.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rxd_meta <= 1'b1;
      rxd_sync <= 1'b1;
      rxd_last <= 1'b1;
      rx_busy  <= 1'b0;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
      rx_valid <= 1'b0;
    end else begin
      rxd_meta <= rxd;
      rxd_sync <= rxd_meta;
      rxd_last <= rxd_sync;
      rx_valid <= 1'b0;
      if (!rx_busy) begin
        if (rxd_last && !rxd_sync) begin
          rx_busy <= 1'b1;
          rx_cnt  <= HALF_BIT;
          rx_bit  <= '0;
        end
      end else if (rx_cnt != '0) begin
        rx_cnt <= rx_cnt - 1'b1;
      end else begin
        rx_cnt <= FULL_BIT;
        rx_bit <= rx_bit + 4'd1;
        if (rx_bit == 4'd0) begin
          if (rxd_sync) rx_busy <= 1'b0;
        end else if (rx_bit == LAST_BIT) begin
          rx_busy  <= 1'b0;
          rx_valid <= rxd_sync;
        end else begin
          rx_shift <= {rxd_sync, rx_shift[7:1]};
        end
      end
    end
  end

  assign rx_data = rx_shift;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tx_busy  <= 1'b0;
      txd_q    <= 1'b1;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
    end else if (!tx_busy) begin
      if (tx_valid) begin
        tx_busy  <= 1'b1;
        txd_q    <= 1'b0;
        tx_shift <= {1'b1, tx_data};
        tx_cnt   <= FULL_BIT;
        tx_bit   <= '0;
      end
    end else if (tx_cnt != '0) begin
      tx_cnt <= tx_cnt - 1'b1;
    end else if (tx_bit == LAST_BIT) begin
      tx_busy <= 1'b0;
    end else begin
      txd_q    <= tx_shift[0];
      tx_shift <= {1'b0, tx_shift[8:1]};
      tx_bit   <= tx_bit + 4'd1;
      tx_cnt   <= FULL_BIT;
    end
  end

  assign tx_ready = !tx_busy;
  // Reset releases the line at once rather than waiting for the next edge.
  assign txd = txd_q | rst_i;

endmodule

// File: rtl/wb_dbg_master.sv
// UART-driven Wishbone debug master: host sends cmd/addr/data, bridge runs one cycle and replies.
// Optional bus timeout enabled by defining WB_DBG_TIMEOUT_EN.
module wb_dbg_master
  import wb_dbg_pkg::*;
#(
  parameter int CLK_DIV = 434,
  parameter int TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        uart_rxd,
  output logic        uart_txd,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  output logic [3:0]  wb_sel_o,
  output logic        wb_we_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  input  logic        wb_ack_i,
  input  logic        wb_err_i,
  input  logic        wb_rty_i
);

  logic [7:0]  rx_data, tx_data;
  logic        rx_valid, tx_valid, tx_ready;
  state_t      state, state_next;
  logic        is_write;
  logic [1:0]  byte_cnt;
  logic [31:0] rdata;
  logic [7:0]  status, resp_status;
  logic        bus_resp, start_bus;

  dbg_uart_phy #(.CLK_DIV(CLK_DIV)) u_phy (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .rxd      (uart_rxd),
    .txd      (uart_txd),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready)
  );

`ifdef WB_DBG_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  logic [TMO_W-1:0] tmo_cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i || start_bus) tmo_cnt <= '0;
    else if (state == ST_BUS) tmo_cnt <= tmo_cnt + 1'b1;
  end
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= ST_IDLE;
    else       state <= state_next;
  end

  // Error outranks retry, which outranks ack, when a slave raises several at once.
  always_comb begin
    state_next  = state;
    tx_valid    = 1'b0;
    tx_data     = status;
    bus_resp    = 1'b0;
    resp_status = STAT_ACK;
    if (wb_err_i)      resp_status = STAT_ERR;
    else if (wb_rty_i) resp_status = STAT_RTY;
    case (state)
      ST_IDLE:
        if (rx_valid && (rx_data == CMD_WRITE || rx_data == CMD_READ)) state_next = ST_ADDR;
      ST_ADDR:
        if (rx_valid && byte_cnt == 2'd3) state_next = is_write ? ST_WDATA : ST_BUS;
      ST_WDATA:
        if (rx_valid && byte_cnt == 2'd3) state_next = ST_BUS;
      ST_BUS: begin
        if (wb_ack_i || wb_err_i || wb_rty_i) begin
          bus_resp   = 1'b1;
          state_next = ST_STAT;
        end
`ifdef WB_DBG_TIMEOUT_EN
        else if (tmo_cnt == TMO_W'(TIMEOUT - 1)) begin
          bus_resp    = 1'b1;
          resp_status = STAT_TMO;
          state_next  = ST_STAT;
        end
`endif
      end
      ST_STAT: begin
        tx_valid = 1'b1;
        if (tx_ready) state_next = (!is_write && status == STAT_ACK) ? ST_RDATA : ST_IDLE;
      end
      ST_RDATA: begin
        tx_valid = 1'b1;
        case (byte_cnt)
          2'd0:    tx_data = rdata[31:24];
          2'd1:    tx_data = rdata[23:16];
          2'd2:    tx_data = rdata[15:8];
          default: tx_data = rdata[7:0];
        endcase
        if (tx_ready && byte_cnt == 2'd3) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign start_bus = (state != ST_BUS) && (state_next == ST_BUS);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wb_adr_o <= '0;
      wb_dat_o <= '0;
      wb_sel_o <= '0;
      wb_we_o  <= 1'b0;
      wb_cyc_o <= 1'b0;
      wb_stb_o <= 1'b0;
      is_write <= 1'b0;
      byte_cnt <= '0;
      rdata    <= '0;
      status   <= '0;
    end else begin
      case (state)
        ST_IDLE:
          if (rx_valid) begin
            is_write <= (rx_data == CMD_WRITE);
            byte_cnt <= '0;
          end
        ST_ADDR:
          if (rx_valid) begin
            wb_adr_o <= {wb_adr_o[23:0], rx_data};
            byte_cnt <= byte_cnt + 2'd1;
          end
        ST_WDATA:
          if (rx_valid) begin
            wb_dat_o <= {wb_dat_o[23:0], rx_data};
            byte_cnt <= byte_cnt + 2'd1;
          end
        ST_BUS:
          if (bus_resp) begin
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
            wb_we_o  <= 1'b0;
            wb_sel_o <= '0;
            status   <= resp_status;
            byte_cnt <= '0;
            if (!is_write && resp_status == STAT_ACK) rdata <= wb_dat_i;
          end
        ST_RDATA:
          if (tx_ready) byte_cnt <= byte_cnt + 2'd1;
        default: ;
      endcase
      if (start_bus) begin
        wb_cyc_o <= 1'b1;
        wb_stb_o <= 1'b1;
        wb_sel_o <= 4'hF;
        wb_we_o  <= is_write;
      end
    end
  end

endmodule

// File: tb/tb_wb_dbg_master.sv
// Self-checking bench for wb_dbg_master: UART host driver, UART reply decoder and Wishbone slave model.
module tb_wb_dbg_master;

  localparam int CLK_DIV = 8;
  localparam int TIMEOUT = 16;
  localparam int M_ACK = 0, M_ERR = 1, M_RTY = 2, M_BOTH = 3, M_NONE = 4;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        uart_rxd = 1'b1;
  logic        uart_txd;
  logic [31:0] wb_adr_o, wb_dat_o;
  logic [31:0] wb_dat_i = '0;
  logic [3:0]  wb_sel_o;
  logic        wb_we_o, wb_cyc_o, wb_stb_o;
  logic        wb_ack_i = 1'b0, wb_err_i = 1'b0, wb_rty_i = 1'b0;

  wb_dbg_master #(.CLK_DIV(CLK_DIV), .TIMEOUT(TIMEOUT)) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .uart_rxd (uart_rxd),
    .uart_txd (uart_txd),
    .wb_adr_o (wb_adr_o),
    .wb_dat_o (wb_dat_o),
    .wb_dat_i (wb_dat_i),
    .wb_sel_o (wb_sel_o),
    .wb_we_o  (wb_we_o),
    .wb_cyc_o (wb_cyc_o),
    .wb_stb_o (wb_stb_o),
    .wb_ack_i (wb_ack_i),
    .wb_err_i (wb_err_i),
    .wb_rty_i (wb_rty_i)
  );

  always #5 clk_i = ~clk_i;

  int errors = 0;
  int checks = 0;

  // slave configuration (written by the main sequence)
  int          resp_mode = M_ACK;
  int          resp_delay = 0;
  logic [31:0] slave_rdata = '0;

  // slave observations (written by the slave process)
  int          n_cycles = 0;
  int          cyc_count = 0;
  bit          drop_ok = 1'b0;
  logic [31:0] cap_adr = '0, cap_dat = '0;
  logic [3:0]  cap_sel = '0;
  logic        cap_we = 1'b0, cap_stb = 1'b0;

  // reply decoder
  logic [7:0] tx_q[$];
  int         tx_starts = 0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] b, input bit good_stop);
    @(negedge clk_i);
    uart_rxd = 1'b0;
    repeat (CLK_DIV) @(negedge clk_i);
    for (int i = 0; i < 8; i++) begin
      uart_rxd = b[i];
      repeat (CLK_DIV) @(negedge clk_i);
    end
    uart_rxd = good_stop;
    repeat (CLK_DIV) @(negedge clk_i);
    uart_rxd = 1'b1;
    repeat (good_stop ? 2 : 2 * CLK_DIV) @(negedge clk_i);
  endtask

  function automatic logic [7:0] expectedStatus(input int mode);
    case (mode)
      M_ACK:   return 8'h00;
      M_ERR:   return 8'hE1;
      M_RTY:   return 8'hE2;
      M_BOTH:  return 8'hE1;
      default: return 8'hE3;
    endcase
  endfunction

  // Wishbone slave: responds resp_delay cycles after the cycle starts, for one cycle.
  initial begin
    bit prev_cyc = 1'b0;
    bit resp_given = 1'b0;
    int wait_cnt = 0;
    forever begin
      @(posedge clk_i);
      #1;
      if (wb_ack_i || wb_err_i || wb_rty_i) begin
        drop_ok  = !wb_cyc_o && !wb_stb_o;
        wb_ack_i = 1'b0;
        wb_err_i = 1'b0;
        wb_rty_i = 1'b0;
      end
      wb_dat_i = $urandom;
      if (wb_cyc_o && !prev_cyc) begin
        cyc_count  = 0;
        wait_cnt   = 0;
        resp_given = 1'b0;
        drop_ok    = 1'b0;
        n_cycles++;
        cap_adr = wb_adr_o;
        cap_dat = wb_dat_o;
        cap_sel = wb_sel_o;
        cap_we  = wb_we_o;
        cap_stb = wb_stb_o;
      end
      if (wb_cyc_o) cyc_count++;
      if (wb_cyc_o && wb_stb_o && !resp_given) begin
        if (resp_mode != M_NONE && wait_cnt == resp_delay) begin
          wb_ack_i   = (resp_mode == M_ACK);
          wb_err_i   = (resp_mode == M_ERR || resp_mode == M_BOTH);
          wb_rty_i   = (resp_mode == M_RTY || resp_mode == M_BOTH);
          wb_dat_i   = slave_rdata;
          resp_given = 1'b1;
        end
        wait_cnt++;
      end
      prev_cyc = wb_cyc_o;
    end
  end

  // UART reply decoder: samples each bit near its middle.
  initial begin
    logic [7:0] b;
    forever begin
      @(negedge uart_txd);
      tx_starts++;
      repeat (CLK_DIV / 2) @(negedge clk_i);
      for (int i = 0; i < 8; i++) begin
        repeat (CLK_DIV) @(negedge clk_i);
        b[i] = uart_txd;
      end
      repeat (CLK_DIV) @(negedge clk_i);
      if (uart_txd) tx_q.push_back(b);
    end
  end

  task automatic sendCommand(input bit rd, input logic [31:0] adr, input logic [31:0] dat);
    applyStimulus(rd ? 8'h02 : 8'h01, 1'b1);
    for (int i = 3; i >= 0; i--) applyStimulus(adr[8*i +: 8], 1'b1);
    if (!rd) for (int i = 3; i >= 0; i--) applyStimulus(dat[8*i +: 8], 1'b1);
  endtask

  task automatic runTxn(input string tag, input bit rd, input logic [31:0] adr,
                        input logic [31:0] dat, input int mode, input int delay,
                        input logic [31:0] rdat);
    logic [7:0] exp_q[$];
    logic [7:0] st;
    int base_cycles;
    int budget;
    resp_mode   = mode;
    resp_delay  = delay;
    slave_rdata = rdat;
    tx_q.delete();
    base_cycles = n_cycles;
    sendCommand(rd, adr, dat);
    st = expectedStatus(mode);
    exp_q.push_back(st);
    if (rd && st == 8'h00) for (int i = 3; i >= 0; i--) exp_q.push_back(rdat[8*i +: 8]);
    budget = (exp_q.size() + 1) * 12 * CLK_DIV + TIMEOUT + 100;
    for (int c = 0; c < budget && tx_q.size() < exp_q.size(); c++) @(negedge clk_i);
    checkOutput({tag, "/txcount"}, 32'(tx_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      if (i < tx_q.size()) checkOutput({tag, "/txbyte"}, 32'(tx_q[i]), 32'(exp_q[i]));
    repeat (12 * CLK_DIV) @(negedge clk_i);
    checkOutput({tag, "/no_extra_tx"}, 32'(tx_q.size()), 32'(exp_q.size()));
    checkOutput({tag, "/one_cycle"}, 32'(n_cycles - base_cycles), 32'd1);
    checkOutput({tag, "/adr"}, cap_adr, adr);
    checkOutput({tag, "/we"}, 32'(cap_we), 32'(!rd));
    checkOutput({tag, "/sel"}, 32'(cap_sel), 32'hF);
    checkOutput({tag, "/stb"}, 32'(cap_stb), 32'd1);
    if (!rd) checkOutput({tag, "/dat"}, cap_dat, dat);
    checkOutput({tag, "/cyc_len"}, 32'(cyc_count), (mode == M_NONE) ? 32'(TIMEOUT) : 32'(delay + 1));
    if (mode != M_NONE) checkOutput({tag, "/drop_next"}, 32'(drop_ok), 32'd1);
    checkOutput({tag, "/cyc_idle"}, 32'(wb_cyc_o), 32'd0);
  endtask

  task automatic resetOutputsCheck(input string tag);
    checkOutput({tag, "/cyc"}, 32'(wb_cyc_o), 32'd0);
    checkOutput({tag, "/stb"}, 32'(wb_stb_o), 32'd0);
    checkOutput({tag, "/we"},  32'(wb_we_o),  32'd0);
    checkOutput({tag, "/sel"}, 32'(wb_sel_o), 32'd0);
    checkOutput({tag, "/adr"}, wb_adr_o, 32'd0);
    checkOutput({tag, "/dat"}, wb_dat_o, 32'd0);
    checkOutput({tag, "/txd"}, 32'(uart_txd), 32'd1);
  endtask

  task automatic waitForCyc(input string tag);
    for (int c = 0; c < 400 && !wb_cyc_o; c++) @(negedge clk_i);
    checkOutput({tag, "/cyc_started"}, 32'(wb_cyc_o), 32'd1);
  endtask

  task automatic resetDuringBus(input string tag);
    int base_starts;
    base_starts = tx_starts;
    @(negedge clk_i);
    rst_i = 1'b1;
    @(posedge clk_i);
    #1;
    resetOutputsCheck(tag);
    @(negedge clk_i);
    rst_i = 1'b0;
    repeat (40 * CLK_DIV) @(negedge clk_i);
    checkOutput({tag, "/no_status"}, 32'(tx_starts - base_starts), 32'd0);
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int base_starts;

    repeat (4) @(negedge clk_i);
    resetOutputsCheck("reset");
    rst_i = 1'b0;
    repeat (4) @(negedge clk_i);

    runTxn("write", 1'b0, 32'h0000_0010, 32'hDEAD_BEEF, M_ACK, 2, 32'h0);
    runTxn("read", 1'b1, 32'hF000_0000, 32'h0, M_ACK, 1, 32'h1234_5678);
    runTxn("err", 1'b1, 32'h0000_0100, 32'h0, M_ERR, 1, 32'hAAAA_5555);
    runTxn("rty", 1'b0, 32'h0000_0200, 32'h0BAD_F00D, M_RTY, 0, 32'h0);
    runTxn("err_rty", 1'b1, 32'h0000_0300, 32'h0, M_BOTH, 3, 32'h5555_AAAA);

    // glitch, non-command byte and framing error must all leave the bridge idle
    tx_q.delete();
    @(negedge clk_i);
    uart_rxd = 1'b0;
    repeat (3) @(negedge clk_i);
    uart_rxd = 1'b1;
    repeat (3 * CLK_DIV) @(negedge clk_i);
    applyStimulus(8'h55, 1'b1);
    applyStimulus(8'h01, 1'b0);
    checkOutput("robust/no_tx", 32'(tx_q.size()), 32'd0);
    runTxn("robust_read", 1'b1, 32'hC0DE_0004, 32'h0, M_ACK, 0, 32'hCAFE_F00D);

    for (int t = 0; t < 6; t++)
      runTxn("random", 1'($urandom_range(0, 1)), $urandom, $urandom,
             int'($urandom_range(0, 3)), int'($urandom_range(0, 4)), $urandom);

    resp_mode = M_NONE;
    sendCommand(1'b1, 32'h8000_0040, 32'h0);
    waitForCyc("rst_bus");
    repeat (5) @(negedge clk_i);
    resetDuringBus("rst_bus");

`ifdef WB_DBG_TIMEOUT_EN
    runTxn("timeout", 1'b1, 32'h4000_0000, 32'h0, M_NONE, 0, 32'h0);
`else
    base_starts = tx_starts;
    sendCommand(1'b1, 32'h4000_0000, 32'h0);
    waitForCyc("no_timeout");
    repeat (1000) @(negedge clk_i);
    checkOutput("no_timeout/cyc_held", 32'(wb_cyc_o), 32'd1);
    checkOutput("no_timeout/stb_held", 32'(wb_stb_o), 32'd1);
    checkOutput("no_timeout/no_tx", 32'(tx_starts - base_starts), 32'd0);
    resetDuringBus("no_timeout_rst");
`endif

    // reset while the first data byte of a read reply is on the wire
    resp_mode   = M_ACK;
    resp_delay  = 0;
    slave_rdata = 32'h1234_5678;
    tx_q.delete();
    base_starts = tx_starts;
    sendCommand(1'b1, 32'h0000_0020, 32'h0);
    for (int c = 0; c < 40 * CLK_DIV && tx_starts < base_starts + 2; c++) @(negedge clk_i);
    checkOutput("rst_tx/second_byte_started", 32'(tx_starts - base_starts), 32'd2);
    repeat (3 * CLK_DIV + 2) @(negedge clk_i);
    rst_i = 1'b1;
    #1;
    checkOutput("rst_tx/txd_immediate", 32'(uart_txd), 32'd1);
    @(posedge clk_i);
    #1;
    resetOutputsCheck("rst_tx");
    @(negedge clk_i);
    rst_i = 1'b0;
    repeat (12 * CLK_DIV) @(negedge clk_i);
    checkOutput("rst_tx/status_byte", (tx_q.size() > 0) ? 32'(tx_q[0]) : 32'hFFFF_FFFF, 32'h00);
    base_starts = tx_starts;
    repeat (50 * CLK_DIV) @(negedge clk_i);
    checkOutput("rst_tx/no_more_tx", 32'(tx_starts - base_starts), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
